// File: rtl/led_pattern_sequencer_pkg.sv
// Package led_seq_pkg: shared types and constants for the LED pattern sequencer.
//   led_mode_e : run-time pattern selector (CHASE_UP, CHASE_DOWN, BOUNCE, FILL)
//   led_dir_e  : BOUNCE travel direction
//   PWM_W      : width of the dimming PWM counter and brightness input
//   pos_width  : width of the BOUNCE position register for a given LED count
package led_seq_pkg;

  typedef enum logic [1:0] {
    CHASE_UP   = 2'd0,
    CHASE_DOWN = 2'd1,
    BOUNCE     = 2'd2,
    FILL       = 2'd3
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } led_dir_e;

  localparam int PWM_W = 4;

  function automatic int pos_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Interface led_pattern_sequencer_if: control inputs, LED outputs and FSM debug
// taps of led_pattern_sequencer.
//   master modport : drives en/mode/div (and bright when LED_SEQ_DIM_EN is defined),
//                    observes leds/step and the dbg_* state taps
//   slave modport  : the sequencer itself
// Signalling: there is no valid/ready pair. en, mode, div (and bright) are
// level inputs sampled on every rising clk edge; step is a one-cycle strobe
// that is high exactly in the cycle leds presents a new pattern step.
// Optional feature macro: LED_SEQ_DIM_EN (adds the bright input).
interface led_pattern_sequencer_if #(
  parameter int N_LEDS = 8,
  parameter int DIV_W  = 24
);
  import led_seq_pkg::*;

  localparam int POS_W = pos_width(N_LEDS);

  logic              en;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  div;
`ifdef LED_SEQ_DIM_EN
  logic [PWM_W-1:0]  bright;
`endif
  logic [N_LEDS-1:0] leds;
  logic              step;

  // FSM state taps for checkers
  led_mode_e         dbg_mode;
  logic [POS_W-1:0]  dbg_pos;
  led_dir_e          dbg_dir;
  logic [DIV_W-1:0]  dbg_cnt;

`ifdef LED_SEQ_DIM_EN
  modport master (output en, mode, div, bright,
                  input  leds, step, dbg_mode, dbg_pos, dbg_dir, dbg_cnt);
  modport slave  (input  en, mode, div, bright,
                  output leds, step, dbg_mode, dbg_pos, dbg_dir, dbg_cnt);
`else
  modport master (output en, mode, div,
                  input  leds, step, dbg_mode, dbg_pos, dbg_dir, dbg_cnt);
  modport slave  (input  en, mode, div,
                  output leds, step, dbg_mode, dbg_pos, dbg_dir, dbg_cnt);
`endif

endinterface

// File: rtl/led_pattern_sequencer_prescaler.sv
// Module led_seq_prescaler: step-rate prescaler for the LED sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable; when low the count holds and no tick is produced
//   clr        : synchronous clear (mode reload), wins over tick and count
//   div        : step period is div+1 enabled cycles
//   tick       : combinational, high in the cycle the pattern should advance
//   cnt        : current count (debug tap)
module led_seq_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic [DIV_W-1:0] cnt
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so that lowering div below the running count fires on
  // the next enabled cycle instead of waiting for a full wrap.
  assign tick = en && (cnt_q >= div);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Module led_pattern_sequencer: N-LED pattern generator with programmable step
// prescaler, enable and four run-time selectable patterns.
//   clk     : system clock, all logic on posedge
//   reset_n : asynchronous active-low reset
//   bus     : led_pattern_sequencer_if.slave (en, mode, div, [bright] in;
//             leds, step and dbg_* state taps out)
// Optional feature macro: LED_SEQ_DIM_EN -- adds bright input and a free-running
// PWM counter that gates the LED drive; pattern and step timing are unchanged.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int DIV_W  = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  led_pattern_sequencer_if.slave  bus
);

  localparam int                POS_W   = pos_width(N_LEDS);
  localparam logic [POS_W-1:0]  POS_MAX = POS_W'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] ONE_LSB = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] ONE_MSB = ONE_LSB << (N_LEDS - 1);

  led_mode_e         mode_q, mode_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  led_dir_e          dir_q, dir_d;
  logic [N_LEDS-1:0] pattern_q, pattern_d;
  logic              step_q, step_d;

  logic              mode_chg;
  logic              tick;
  logic [DIV_W-1:0]  cnt;

  // A mode change is acted on regardless of en and overrides any tick.
  assign mode_chg = (bus.mode != 2'(mode_q));

  led_seq_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst_n(reset_n),
    .en   (bus.en),
    .clr  (mode_chg),
    .div  (bus.div),
    .tick (tick),
    .cnt  (cnt)
  );

  always_comb begin
    mode_d    = mode_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    pattern_d = pattern_q;
    step_d    = 1'b0;
    if (mode_chg) begin
      mode_d = led_mode_e'(bus.mode);
      pos_d  = '0;
      dir_d  = DIR_UP;
      case (mode_d)
        CHASE_UP:   pattern_d = ONE_LSB;
        CHASE_DOWN: pattern_d = ONE_MSB;
        BOUNCE:     pattern_d = ONE_LSB;
        default:    pattern_d = '0;
      endcase
    end else if (tick) begin
      step_d = 1'b1;
      case (mode_q)
        CHASE_UP:   pattern_d = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
        CHASE_DOWN: pattern_d = {pattern_q[0], pattern_q[N_LEDS-1:1]};
        BOUNCE: begin
          // Turn around on the end LED itself so the ends are shown once.
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_MAX) begin
              dir_d = DIR_DOWN;
              pos_d = pos_q - POS_W'(1);
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = POS_W'(1);
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
          pattern_d = ONE_LSB << pos_d;
        end
        default: begin
          // Thermometer fill; the all-ones step is followed by a clear.
          pattern_d = (&pattern_q) ? '0 : {pattern_q[N_LEDS-2:0], 1'b1};
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= CHASE_UP;
      pos_q     <= '0;
      dir_q     <= DIR_UP;
      pattern_q <= ONE_LSB;
      step_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      pattern_q <= pattern_d;
      step_q    <= step_d;
    end
  end

`ifdef LED_SEQ_DIM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             dim_on;

  assign pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
  // Full scale is treated as always-on so bright=15 gives 16/16, not 15/16.
  assign dim_on    = (pwm_cnt_q < bus.bright) || (bus.bright == {PWM_W{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign bus.leds = pattern_q & {N_LEDS{dim_on}};
`else
  assign bus.leds = pattern_q;
`endif

  assign bus.step     = step_q;
  assign bus.dbg_mode = mode_q;
  assign bus.dbg_pos  = pos_q;
  assign bus.dbg_dir  = dir_q;
  assign bus.dbg_cnt  = cnt;

endmodule
